dice_race_game_controller: RTL and testbench



---
 rtl/dice_race_game_controller.sv | 139 +++++++++++++
 tb/tb_dice_race_game_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_race_game_controller.sv
// Dice race game-flow sequencer: runs intro menu -> play -> win, owns player
// positions, the active turn and winner state, and paces each move on the
// renderer's turn_done handshake, with a timeout fallback.
module dice_race_game_controller #(
  parameter int unsigned NUM_TILES    = 16,
  parameter int unsigned ANIM_TIMEOUT = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       dice_valid,
  input  logic [2:0] dice_value,
  input  logic       turn_done,
  output logic       is_intro_state,
  output logic       menu_select,
  output logic [3:0] p1_pos,
  output logic [3:0] p2_pos,
  output logic       pos_valid,
  output logic       turn,
  output logic       winner_valid,
  output logic       winner
);

  localparam int unsigned CntW = (ANIM_TIMEOUT > 1) ? $clog2(ANIM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ANIM_TIMEOUT - 1);
  localparam logic [3:0] Goal = 4'(NUM_TILES - 1);

  typedef enum logic [2:0] {
    StIntro,
    StWaitDice,
    StWaitAnim,
    StWin,
    StHalt
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic [3:0] active_pos;
  logic [4:0] pos_sum;
  logic [3:0] moved_pos;
  logic       dice_ok;
  logic       anim_done;

  // Move arithmetic for the active player and the turn-completion condition.
  always_comb begin
    active_pos = turn ? p2_pos : p1_pos;
    pos_sum    = {1'b0, active_pos} + {2'b00, dice_value};
    moved_pos  = (pos_sum > {1'b0, Goal}) ? Goal : pos_sum[3:0];
    dice_ok    = dice_valid && (dice_value != 3'd0) && (dice_value != 3'd7);
    // pos_valid is high only in the first WAIT_ANIM cycle, so a turn_done
    // arriving then belongs to the previous move and is dropped.
    anim_done  = (turn_done && !pos_valid) || (cnt_q == CntLast);
  end

  // Game FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIntro;
      cnt_q          <= '0;
      is_intro_state <= 1'b1;
      menu_select    <= 1'b0;
      p1_pos         <= 4'd0;
      p2_pos         <= 4'd0;
      pos_valid      <= 1'b0;
      turn           <= 1'b0;
      winner_valid   <= 1'b0;
      winner         <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      unique case (state_q)
        StIntro: begin
          if (btn_up && !btn_down) begin
            menu_select <= 1'b0;
          end else if (btn_down && !btn_up) begin
            menu_select <= 1'b1;
          end
          if (btn_select) begin
            is_intro_state <= 1'b0;
            if (!menu_select) begin
              p1_pos  <= 4'd0;
              p2_pos  <= 4'd0;
              turn    <= 1'b0;
              state_q <= StWaitDice;
            end else begin
              state_q <= StHalt;
            end
          end
        end
        StWaitDice: begin
          if (dice_ok) begin
            if (turn) begin
              p2_pos <= moved_pos;
            end else begin
              p1_pos <= moved_pos;
            end
            pos_valid <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StWaitAnim;
          end
        end
        StWaitAnim: begin
          if (anim_done) begin
            if (active_pos == Goal) begin
              winner_valid <= 1'b1;
              winner       <= turn;
              state_q      <= StWin;
            end else begin
              turn    <= ~turn;
              state_q <= StWaitDice;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWin: begin
          if (btn_select) begin
            winner_valid   <= 1'b0;
            p1_pos         <= 4'd0;
            p2_pos         <= 4'd0;
            turn           <= 1'b0;
            menu_select    <= 1'b0;
            is_intro_state <= 1'b1;
            state_q        <= StIntro;
          end
        end
        StHalt: begin
          // Terminal until reset.
        end
        default: begin
          state_q <= StIntro;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dice_race_game_controller.sv
// Directed self-checking bench for dice_race_game_controller, built with a
// short animation timeout so the timeout path is exercised quickly.
module tb_dice_race_game_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_select = 1'b0;
  logic       dice_valid = 1'b0;
  logic [2:0] dice_value = 3'd0;
  logic       turn_done = 1'b0;
  logic       is_intro_state;
  logic       menu_select;
  logic [3:0] p1_pos;
  logic [3:0] p2_pos;
  logic       pos_valid;
  logic       turn;
  logic       winner_valid;
  logic       winner;

  int vectors = 0;
  int errors = 0;

  // {intro, menu, p1, p2, pos_valid, turn, winner_valid, winner}
  logic [15:0] obs;
  logic [15:0] exp_v;
  assign obs = {is_intro_state, menu_select, p1_pos, p2_pos, pos_valid, turn,
                winner_valid, winner};

  dice_race_game_controller #(
    .NUM_TILES   (16),
    .ANIM_TIMEOUT(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_select    (btn_select),
    .dice_valid    (dice_valid),
    .dice_value    (dice_value),
    .turn_done     (turn_done),
    .is_intro_state(is_intro_state),
    .menu_select   (menu_select),
    .p1_pos        (p1_pos),
    .p2_pos        (p2_pos),
    .pos_valid     (pos_valid),
    .turn          (turn),
    .winner_valid  (winner_valid),
    .winner        (winner)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] st(input logic intro, input logic menu,
                                     input logic [3:0] p1, input logic [3:0] p2,
                                     input logic pv, input logic t,
                                     input logic wv, input logic w);
    return {intro, menu, p1, p2, pv, t, wv, w};
  endfunction

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
    dice_valid = 1'b0; dice_value = 3'd0; turn_done = 1'b0;
  endtask

  task automatic roll(input logic [2:0] v);
    dice_valid = 1'b1; dice_value = v;
    tick();
    clear_inputs();
  endtask

  // Full turn: roll, one idle cycle, then turn_done.
  task automatic do_turn(input logic [2:0] v);
    roll(v);
    tick();
    turn_done = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    exp_v = st(1, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs, exp_v);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_menu();
    btn_down = 1'b1; tick(); clear_inputs();
    exp_v = st(1, 1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL menu_down: got %h want %h", obs, exp_v);
    end
    btn_up = 1'b1; btn_down = 1'b1; tick(); clear_inputs();
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL menu_up_down: got %h want %h", obs, exp_v);
    end
    btn_up = 1'b1; tick(); clear_inputs();
    exp_v = st(1, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL menu_up: got %h want %h", obs, exp_v);
    end
    dice_valid = 1'b1; dice_value = 3'd3; turn_done = 1'b1; tick(); clear_inputs();
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL intro_ignores_dice: got %h want %h", obs, exp_v);
    end
    btn_select = 1'b1; tick(); clear_inputs();
    exp_v = st(0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL menu_start: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_normal_turn();
    roll(3'd4);
    exp_v = st(0, 0, 4, 0, 1, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL p1_roll4: got %h want %h", obs, exp_v);
    end
    tick();
    exp_v = st(0, 0, 4, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL pos_valid_single: got %h want %h", obs, exp_v);
    end
    tick();
    turn_done = 1'b1; tick(); clear_inputs();
    exp_v = st(0, 0, 4, 0, 0, 1, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL turn_toggle: got %h want %h", obs, exp_v);
    end
    roll(3'd0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL dice0_ignored: got %h want %h", obs, exp_v);
    end
    roll(3'd7);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL dice7_ignored: got %h want %h", obs, exp_v);
    end
    roll(3'd6);
    exp_v = st(0, 0, 4, 6, 1, 1, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL p2_roll6: got %h want %h", obs, exp_v);
    end
    tick();
    turn_done = 1'b1; tick(); clear_inputs();
    exp_v = st(0, 0, 4, 6, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL turn_back_p1: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_saturation_win();
    do_turn(3'd6);  // p1 10
    do_turn(3'd1);  // p2 7
    do_turn(3'd2);  // p1 12
    do_turn(3'd1);  // p2 8
    exp_v = st(0, 0, 12, 8, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL setup_p1_12: got %h want %h", obs, exp_v);
    end
    roll(3'd5);
    exp_v = st(0, 0, 15, 8, 1, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL saturate_15: got %h want %h", obs, exp_v);
    end
    tick();
    turn_done = 1'b1; tick(); clear_inputs();
    exp_v = st(0, 0, 15, 8, 0, 0, 1, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL win_p1: got %h want %h", obs, exp_v);
    end
    btn_down = 1'b1; dice_valid = 1'b1; dice_value = 3'd2; turn_done = 1'b1;
    tick(); clear_inputs();
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL win_hold: got %h want %h", obs, exp_v);
    end
    btn_select = 1'b1; tick(); clear_inputs();
    exp_v = st(1, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL win_to_intro: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_timeout();
    btn_select = 1'b1; tick(); clear_inputs();
    roll(3'd3);
    exp_v = st(0, 0, 3, 0, 1, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL to_roll3: got %h want %h", obs, exp_v);
    end
    // Stale turn_done coincident with pos_valid.
    turn_done = 1'b1; tick(); clear_inputs();
    exp_v = st(0, 0, 3, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL stale_turn_done: got %h want %h", obs, exp_v);
    end
    for (int i = 2; i <= 16; i++) begin
      if (i == 2) begin
        dice_valid = 1'b1; dice_value = 3'd5;
      end
      tick();
      clear_inputs();
      if (i == 15) begin
        exp_v = st(0, 0, 3, 0, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin
          errors++; $display("FAIL timeout_early: got %h want %h", obs, exp_v);
        end
      end
    end
    exp_v = st(0, 0, 3, 0, 0, 1, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL timeout_toggle: got %h want %h", obs, exp_v);
    end
    roll(3'd2);
    exp_v = st(0, 0, 3, 2, 1, 1, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL after_timeout_p2: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_game();
    tick();
    turn_done = 1'b1; tick(); clear_inputs();
    roll(3'd4);
    exp_v = st(0, 0, 7, 2, 1, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL p1_at_7: got %h want %h", obs, exp_v);
    end
    tick();
    #2 reset = 1'b1;
    #1;
    exp_v = st(1, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_mid_anim: got %h want %h", obs, exp_v);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_end_game();
    btn_down = 1'b1; tick(); clear_inputs();
    btn_select = 1'b1; tick(); clear_inputs();
    exp_v = st(0, 1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL halt_enter: got %h want %h", obs, exp_v);
    end
    btn_up = 1'b1; tick(); clear_inputs();
    btn_select = 1'b1; dice_valid = 1'b1; dice_value = 3'd3; tick(); clear_inputs();
    turn_done = 1'b1; tick(); clear_inputs();
    roll(3'd6);
    vectors++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL halt_hold: got %h want %h", obs, exp_v);
    end
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_menu();
    test_normal_turn();
    test_saturation_win();
    test_timeout();
    test_reset_mid_game();
    test_end_game();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
